rr_mux3_arbiter: RTL
====================

Name: rr_mux3_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-1 WIDTH-bit multiplexer between three requesters (U=0, V=1, W=2).
- Drives the mux select S[1:0] from its grant and registers the mux output.
- Caps each grant at HOLD cycles so no requester can starve the others.
- Sits between three producer blocks and a single shared consumer (LED/display path, downstream register).

Parameters:
- WIDTH, 2, data width of each requester input and of M.
- HOLD, 4, maximum consecutive cycles one grant may be held; legal range 1..15; counter is 4 bits.

Ports:
- Clock  input  1  single system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  3  request lines; Req[i] high means requester i wants the mux.
- U  input  WIDTH  data from requester 0.
- V  input  WIDTH  data from requester 1.
- W  input  WIDTH  data from requester 2.
- Grant  output  3  registered one-hot grant, or 000 when nobody is granted.
- S  output  2  registered mux select: 00 selects U, 01 selects V, 10 selects W; 11 is never driven.
- M  output  WIDTH  registered mux output.
- Valid  output  1  registered; high when M holds data from a granted requester.

Behaviour:
- Reset, sampled at a rising edge with Reset=1:
  - State=IDLE, Grant=000, S=00, M=0, Valid=0, cnt=0.
  - Priority pointer last=2, so requester 0 has first priority after reset.
  - Reset overrides every other event, including mid-grant.
- Mux function, combinational and internal: sel_data = U when S=00, V when S=01, W when S=10.
  - Data path: M <= sel_data when Grant!=000, else M <= 0.
  - Valid <= (Grant != 000).
  - Result: data appears on M one cycle after Grant/S change.
  - Latency from Req rising to Grant is 1 cycle; Req rising to Valid is 2 cycles.
- Winner function, used for all arbitration:
  - Search Req in order last+1, last+2, last+3 (mod 3).
  - The first asserted bit wins, so the previous owner has lowest priority but still wins if it is the only requester.
- State IDLE:
  - If Req==000: stay in IDLE, Grant=000, S=00.
  - Else: Grant <= one-hot(winner), S <= winner encoded, cnt <= 0, go to GRANT.
- State GRANT, owner = index of Grant. Release condition = Req[owner]==0 OR cnt==HOLD-1.
  - No release: cnt <= cnt+1; Grant and S hold.
  - Release with Req==000 (after dropping owner if Req[owner]==0): last <= owner, Grant <= 000, S <= 00, go to IDLE.
  - Release with other requests pending: last <= owner, winner computed with the updated pointer, Grant/S <= winner, cnt <= 0, stay in GRANT. There is no idle bubble between grants.
- Req[owner] dropping is seen at the edge where it is sampled low; Grant changes on that same edge.
- Changes to Req of non-owners during a grant have no effect until release.
- Grant is always 000 or exactly one-hot. S always matches Grant (000→00, 001→00, 010→01, 100→10).
- U/V/W are sampled every cycle; there is no data hold requirement on requesters beyond their own grant window.

Test Plan:
- Reset, then Req=001 with U=2'b10 from cycle 0 → cycle 1: Grant=001, S=00, Valid=0; cycle 2: M=2'b10, Valid=1.
- Req=111 held, HOLD=4, starting from reset → Grant sequence is 001×4, 010×4, 100×4, 001×4 with no 000 gaps; S follows as 00, 01, 10; M tracks U, V, W one cycle later.
- Only Req=010 held, HOLD=4 → Grant=010 continuously, including across the 4-cycle re-arbitration; Valid stays 1; cnt wraps 0..3.
- Req=101 with owner 0 granted; Req[0] drops after 2 granted cycles → on the edge sampling Req[0]=0, Grant=100, S=10; M=W the following cycle.
- last=1 (requester 1 just released), Req=110 → next Grant=100 (requester 2 before requester 1); after HOLD cycles, Grant=010.
- Reset=1 for one cycle while Grant=010 and cnt=2 → next edge: Grant=000, S=00, M=0, Valid=0. With Req=111 after reset, first Grant=001.

Source files
------------

// File: rtl/rr_mux3_arbiter_if.sv
// Bundle of the three requester lanes and the shared mux result.
// Producers drive req/u/v/w; the arbiter returns the grant, the select and the registered mux output.
interface rr_mux3_arbiter_if #(
  parameter int WIDTH = 2
);
  logic [2:0]       req;
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] w;
  logic [2:0]       grant;
  logic [1:0]       s;
  logic [WIDTH-1:0] m;
  logic             valid;

  modport master (
    output req, u, v, w,
    input  grant, s, m, valid
  );

  modport slave (
    input  req, u, v, w,
    output grant, s, m, valid
  );
endinterface

// File: rtl/rr_mux3_arbiter.sv
// Round-robin arbiter in front of a shared 3:1 mux, with each grant capped at HOLD cycles.
// M and valid follow grant/S by one cycle.
//
// state   | meaning
// ST_IDLE | nobody owns the mux; grant=000, S=00
// ST_GRANT| one requester owns the mux; cnt counts cycles held
module rr_mux3_arbiter #(
  parameter int WIDTH = 2,
  parameter int HOLD  = 4
) (
  input  logic                clk,
  input  logic                rst,
  rr_mux3_arbiter_if.slave    bus
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       s_q, s_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [WIDTH-1:0] m_q;
  logic             valid_q;
  logic [WIDTH-1:0] sel_data;
  logic             release_now;
  logic [1:0]       winner;

  // Searches last+1, last+2, last+3 (mod 3); the nearest asserted request wins.
  function automatic logic [1:0] pick_winner(input logic [2:0] r, input logic [1:0] lst);
    logic [1:0] idx;
    pick_winner = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((32'(lst) + k) % 3);
      if (r[idx]) pick_winner = idx;
    end
  endfunction

  always_comb begin
    sel_data = '0;
    case (s_q)
      2'd0:    sel_data = bus.u;
      2'd1:    sel_data = bus.v;
      2'd2:    sel_data = bus.w;
      default: sel_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    release_now = 1'b0;
    winner      = 2'd0;

    case (state_q)
      ST_IDLE: begin
        grant_d = 3'b000;
        s_d     = 2'd0;
        if (bus.req != 3'b000) begin
          winner  = pick_winner(bus.req, last_q);
          grant_d = 3'b001 << winner;
          s_d     = winner;
          cnt_d   = 4'd0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        release_now = !bus.req[s_q] || (cnt_q == 4'(HOLD - 1));
        if (!release_now) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          // s_q is the owner's index, so the owner becomes lowest priority.
          last_d = s_q;
          if (bus.req == 3'b000) begin
            grant_d = 3'b000;
            s_d     = 2'd0;
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            winner  = pick_winner(bus.req, s_q);
            grant_d = 3'b001 << winner;
            s_d     = winner;
            cnt_d   = 4'd0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 3'b000;
        s_d     = 2'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 3'b000;
      s_q     <= 2'd0;
      cnt_q   <= 4'd0;
      last_q  <= 2'd2;
      m_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      m_q     <= (grant_q != 3'b000) ? sel_data : '0;
      valid_q <= (grant_q != 3'b000);
    end
  end

  assign bus.grant = grant_q;
  assign bus.s     = s_q;
  assign bus.m     = m_q;
  assign bus.valid = valid_q;

endmodule
